// File: rtl/sd2vc_sched.sv
// Round-robin scheduler that merges several srdy/drdy producers onto one credit-based
// output link. Each producer is a virtual channel with its own credit counter.
module sd2vc_sched #(
  parameter int width    = 8,
  parameter int channels = 4,
  parameter int vc_sz    = 2,
  parameter int cc_sz    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [channels-1:0]       c_srdy,
  output logic [channels-1:0]       c_drdy,
  input  logic [channels*width-1:0] c_data,
  output logic                      p_vld,
  output logic [vc_sz-1:0]          p_vc,
  output logic [width-1:0]          p_data,
  input  logic [channels-1:0]       p_cr
);

  logic [cc_sz-1:0]    cc [channels];
  logic [vc_sz-1:0]    last;
  logic [channels-1:0] elig;
  logic [channels-1:0] grant;
  logic [vc_sz-1:0]    gidx;
  logic [width-1:0]    gdata;
  logic                any_grant;

  // A grant and a returned credit in the same cycle cancel; saturated returns are dropped.
  function automatic logic [cc_sz-1:0] cc_next(input logic [cc_sz-1:0] cur,
                                               input logic g, input logic r);
    cc_next = cur;
    if (g && !r)
      cc_next = cur - cc_sz'(1);
    else if (r && !g && (cur != '1))
      cc_next = cur + cc_sz'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < channels; i++)
      elig[i] = c_srdy[i] && (cc[i] != '0);
  end

  // Search indices above last first, then wrap to 0..last; all indexing stays constant.
  always_comb begin
    grant     = '0;
    gidx      = last;
    gdata     = '0;
    any_grant = 1'b0;
    for (int i = 0; i < channels; i++) begin
      if (!any_grant && elig[i] && (i > int'(last))) begin
        grant[i]  = 1'b1;
        gidx      = vc_sz'(i);
        gdata     = c_data[i*width +: width];
        any_grant = 1'b1;
      end
    end
    for (int i = 0; i < channels; i++) begin
      if (!any_grant && elig[i] && (i <= int'(last))) begin
        grant[i]  = 1'b1;
        gidx      = vc_sz'(i);
        gdata     = c_data[i*width +: width];
        any_grant = 1'b1;
      end
    end
  end

  assign c_drdy = grant;

  // Output stage boundary: control state is reset, data is not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_vld <= 1'b0;
      p_vc  <= '0;
      last  <= vc_sz'(channels - 1);
      for (int i = 0; i < channels; i++)
        cc[i] <= '0;
    end else begin
      p_vld <= any_grant;
      if (any_grant) begin
        p_vc <= gidx;
        last <= gidx;
      end
      for (int i = 0; i < channels; i++)
        cc[i] <= cc_next(cc[i], grant[i], p_cr[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (any_grant)
      p_data <= gdata;
  end

endmodule

// File: tb/tb_sd2vc_sched.sv
// Directed bench for sd2vc_sched: stimulus queues expected {vc,data} words and a
// monitor pops and compares them whenever p_vld is seen.
module tb_sd2vc_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  c_srdy;
  logic [3:0]  c_drdy;
  logic [31:0] c_data;
  logic        p_vld;
  logic [1:0]  p_vc;
  logic [7:0]  p_data;
  logic [3:0]  p_cr;
  logic [7:0]  dat [4];

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q [$];

  assign c_data = {dat[3], dat[2], dat[1], dat[0]};

  sd2vc_sched #(.width(8), .channels(4), .vc_sz(2), .cc_sz(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .c_srdy (c_srdy),
    .c_drdy (c_drdy),
    .c_data (c_data),
    .p_vld  (p_vld),
    .p_vc   (p_vc),
    .p_data (p_data),
    .p_cr   (p_cr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Entered at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic step(input logic [3:0] exp_drdy, input string nm);
    #1;
    chk(nm, 32'(c_drdy), 32'(exp_drdy));
    for (int i = 0; i < 4; i++)
      if (exp_drdy[i]) exp_q.push_back({2'(i), dat[i]});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    c_srdy = 4'b0000;
    p_cr   = 4'b0000;
    reset  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic chk_cc(input string nm, input logic [1:0] e0, input logic [1:0] e1,
                        input logic [1:0] e2, input logic [1:0] e3);
    chk({nm, "_cc0"}, 32'(dut.cc[0]), 32'(e0));
    chk({nm, "_cc1"}, 32'(dut.cc[1]), 32'(e1));
    chk({nm, "_cc2"}, 32'(dut.cc[2]), 32'(e2));
    chk({nm, "_cc3"}, 32'(dut.cc[3]), 32'(e3));
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (p_vld === 1'b1) begin
      logic [9:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected got vc=%0d data=%0h want none at %0t", p_vc, p_data, $time);
      end else begin
        e = exp_q.pop_front();
        if ({p_vc, p_data} !== e) begin
          errors++;
          $display("FAIL out_word got vc=%0d data=%0h want vc=%0d data=%0h at %0t",
                   p_vc, p_data, e[9:8], e[7:0], $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

  initial begin
    dat[0] = 8'h10; dat[1] = 8'h21; dat[2] = 8'hA5; dat[3] = 8'h43;
    reset  = 1'b0;
    c_srdy = 4'b1111;
    p_cr   = 4'b0000;

    // Reset with no credits: nothing may be granted.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_drdy", 32'(c_drdy), 32'h0);
    chk("rst_pvld", 32'(p_vld), 32'h0);
    chk("rst_pvc", 32'(p_vc), 32'h0);
    chk_cc("rst", 2'd0, 2'd0, 2'd0, 2'd0);
    reset = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step(4'b0000, "nocred_drdy");
      chk("nocred_pvld", 32'(p_vld), 32'h0);
    end
    chk_cc("nocred", 2'd0, 2'd0, 2'd0, 2'd0);

    // Single channel: three separated credit pulses on ch2.
    c_srdy = 4'b0000;
    for (int n = 0; n < 3; n++) begin
      p_cr = 4'b0100; step(4'b0000, "single_load");
      p_cr = 4'b0000; step(4'b0000, "single_load");
    end
    chk_cc("single_loaded", 2'd0, 2'd0, 2'd3, 2'd0);
    c_srdy = 4'b0100;
    step(4'b0100, "single_g1");
    step(4'b0100, "single_g2");
    step(4'b0100, "single_g3");
    step(4'b0000, "single_done");
    step(4'b0000, "single_done");
    chk_cc("single_end", 2'd0, 2'd0, 2'd0, 2'd0);

    // Round-robin over four channels with three credits each.
    do_reset();
    p_cr = 4'b1111;
    for (int n = 0; n < 3; n++) step(4'b0000, "rr_load");
    p_cr = 4'b0000;
    chk_cc("rr_loaded", 2'd3, 2'd3, 2'd3, 2'd3);
    dat[0] = 8'h01; dat[1] = 8'h12; dat[2] = 8'h23; dat[3] = 8'h34;
    c_srdy = 4'b1111;
    for (int n = 0; n < 3; n++) begin
      step(4'b0001, "rr_g0");
      step(4'b0010, "rr_g1");
      step(4'b0100, "rr_g2");
      step(4'b1000, "rr_g3");
    end
    step(4'b0000, "rr_done");
    chk("rr_pvld_low", 32'(p_vld), 32'h0);
    chk_cc("rr_end", 2'd0, 2'd0, 2'd0, 2'd0);

    // Channels without credit are skipped.
    do_reset();
    p_cr = 4'b0101;
    step(4'b0000, "skip_load");
    step(4'b0000, "skip_load");
    p_cr = 4'b0000;
    chk_cc("skip_loaded", 2'd2, 2'd0, 2'd2, 2'd0);
    c_srdy = 4'b1111;
    step(4'b0001, "skip_g0a");
    step(4'b0100, "skip_g2a");
    step(4'b0001, "skip_g0b");
    step(4'b0100, "skip_g2b");
    step(4'b0000, "skip_done");
    step(4'b0000, "skip_done");

    // Grant and credit return in the same cycle.
    do_reset();
    p_cr = 4'b0010;
    step(4'b0000, "simul_load");
    chk_cc("simul_loaded", 2'd0, 2'd1, 2'd0, 2'd0);
    c_srdy = 4'b0010;
    step(4'b0010, "simul_g1");
    chk_cc("simul_hold", 2'd0, 2'd1, 2'd0, 2'd0);
    p_cr = 4'b0000;
    step(4'b0010, "simul_g2");
    chk_cc("simul_dec", 2'd0, 2'd0, 2'd0, 2'd0);
    step(4'b0000, "simul_done");

    // Saturation: five returns leave three credits.
    do_reset();
    p_cr = 4'b0001;
    for (int n = 0; n < 5; n++) step(4'b0000, "sat_load");
    p_cr = 4'b0000;
    chk_cc("sat_loaded", 2'd3, 2'd0, 2'd0, 2'd0);
    c_srdy = 4'b0001;
    step(4'b0001, "sat_g1");
    step(4'b0001, "sat_g2");
    step(4'b0001, "sat_g3");
    step(4'b0000, "sat_done");

    // Asynchronous reset in the middle of a burst.
    c_srdy = 4'b0000;
    p_cr   = 4'b0010;
    for (int n = 0; n < 3; n++) step(4'b0000, "ar_load");
    p_cr   = 4'b0000;
    c_srdy = 4'b0010;
    step(4'b0010, "ar_g1");
    chk("ar_pvld_high", 32'(p_vld), 32'h1);
    #5;
    reset = 1'b0;
    #1;
    chk("ar_pvld_async", 32'(p_vld), 32'h0);
    chk("ar_drdy_async", 32'(c_drdy), 32'h0);
    chk_cc("ar_async", 2'd0, 2'd0, 2'd0, 2'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int n = 0; n < 4; n++) step(4'b0000, "ar_after");
    c_srdy = 4'b0000;
    step(4'b0000, "ar_idle");

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
